// File: rtl/sram_like_arbiter_pkg.sv
// Shared IDs, request payload layout and lock state for the SRAM-like arbiter.
// Tag value doubles as the requester ID stored in the order FIFO.
package sram_like_arbiter_pkg;

  localparam logic ARB_ID_INST      = 1'b0;
  localparam logic ARB_ID_DATA      = 1'b1;
  localparam int   SRAM_LIKE_REQ_WD = 67;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sram_req_t;

  typedef enum logic {
    LK_IDLE = 1'b0,
    LK_HELD = 1'b1
  } lock_state_e;

endpackage

// File: rtl/sram_like_arbiter_tag_fifo.sv
// In-order 1-bit tag FIFO; push/pop act on the next edge and head is read combinationally.
// Pushes while full and pops while empty are ignored.
module arb_tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic push_tag,
  input  logic pop,
  output logic head,
  output logic full,
  output logic empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_tag;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like master between inst and data requesters; 0-cycle comb accept/response path.
// Grant is held across a stalled address handshake; m_req drops while the order FIFO is full.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata,
  output logic        err_orphan
);

  lock_state_e lock_q, lock_d;
  logic        lock_id_q, lock_id_d;
  logic        err_orphan_q, err_orphan_d;
  logic        grant_id, granted_req, locked_req, accept;
  logic        fifo_full, fifo_empty, fifo_head, pop;
  sram_req_t   inst_pl, data_pl, m_pl;

  assign inst_pl = {inst_wr, inst_size, inst_addr, inst_wdata};
  assign data_pl = {data_wr, data_size, data_addr, data_wdata};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_q       <= LK_IDLE;
      lock_id_q    <= ARB_ID_INST;
      err_orphan_q <= 1'b0;
    end else begin
      lock_q       <= lock_d;
      lock_id_q    <= lock_id_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  // A stalled handshake pins the grant; leaving m_req low or getting addr_ok releases it.
  always_comb begin
    lock_d    = LK_IDLE;
    lock_id_d = lock_id_q;
    if (m_req && !m_addr_ok) begin
      lock_d    = LK_HELD;
      lock_id_d = grant_id;
    end
  end

  // A locked requester that drops its req forfeits the lock and the grant re-arbitrates.
  assign locked_req = (lock_id_q == ARB_ID_DATA) ? data_req : inst_req;
  always_comb begin
    grant_id = ARB_ID_INST;
    if (lock_q == LK_HELD && locked_req) begin
      grant_id = lock_id_q;
    end else if (data_req) begin
      grant_id = ARB_ID_DATA;
    end
  end

  assign granted_req  = (grant_id == ARB_ID_DATA) ? data_req : inst_req;
  assign m_req        = granted_req && !fifo_full && resetn;
  assign m_pl         = (grant_id == ARB_ID_DATA) ? data_pl : inst_pl;
  assign m_wr         = m_pl.wr;
  assign m_size       = m_pl.size;
  assign m_addr       = m_pl.addr;
  assign m_wdata      = m_pl.wdata;
  assign accept       = m_req && m_addr_ok;
  assign inst_addr_ok = accept && (grant_id == ARB_ID_INST);
  assign data_addr_ok = accept && (grant_id == ARB_ID_DATA);

  assign pop          = m_data_ok && !fifo_empty;
  assign inst_data_ok = pop && (fifo_head == ARB_ID_INST);
  assign data_data_ok = pop && (fifo_head == ARB_ID_DATA);
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;
  assign err_orphan_d = err_orphan_q || (m_data_ok && fifo_empty);
  assign err_orphan   = err_orphan_q;

  arb_tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (accept),
    .push_tag (grant_id),
    .pop      (pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench: expected response tags queue up as requests are driven and are popped on m_data_ok.
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        m_req, m_wr, m_addr_ok, m_data_ok, err_orphan;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int checks   = 0;
  int failures = 0;
  logic sb_q[$];

  always #5 clk = ~clk;

  sram_like_arbiter #(.DEPTH(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata), .err_orphan(err_orphan)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check both response ports against the next expected tag in the same cycle as m_data_ok.
  task automatic check_resp(input string tag, input logic [31:0] v);
    logic t;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    t = sb_q.pop_front();
    chk({tag, "_inst_data_ok"}, {31'd0, inst_data_ok}, {31'd0, t == 1'b0});
    chk({tag, "_data_data_ok"}, {31'd0, data_data_ok}, {31'd0, t == 1'b1});
    chk({tag, "_rdata"}, (t ? data_rdata : inst_rdata), v);
  endtask

  task automatic resp(input string tag, input logic [31:0] v);
    m_data_ok = 1'b1;
    m_rdata   = v;
    @(negedge clk);
    check_resp(tag, v);
    tick();
    m_data_ok = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'hBFC0_0000; inst_wdata = '0;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd1; data_addr = 32'h0000_1000;
    data_wdata = 32'hDEAD_BEEF;
    m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = '0;

    // Reset: everything quiet despite active inputs.
    @(negedge clk);
    chk("rst_m_req", {31'd0, m_req}, 32'd0);
    chk("rst_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    chk("rst_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
    chk("rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    chk("rst_err", {31'd0, err_orphan}, 32'd0);
    tick();
    inst_req = 1'b0; data_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0;
    resetn = 1'b1;
    tick();

    // Simultaneous requests: data first, then inst.
    inst_req = 1'b1; data_req = 1'b1; m_addr_ok = 1'b1;
    @(negedge clk);
    chk("t1_m_req", {31'd0, m_req}, 32'd1);
    chk("t1_addr0", m_addr, 32'h0000_1000);
    chk("t1_wdata0", m_wdata, 32'hDEAD_BEEF);
    chk("t1_size0", {30'd0, m_size}, 32'd1);
    chk("t1_wr0", {31'd0, m_wr}, 32'd1);
    chk("t1_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    chk("t1_inst_addr_ok0", {31'd0, inst_addr_ok}, 32'd0);
    sb_q.push_back(1'b1);
    tick();
    data_req = 1'b0;
    @(negedge clk);
    chk("t1_addr1", m_addr, 32'hBFC0_0000);
    chk("t1_wr1", {31'd0, m_wr}, 32'd0);
    chk("t1_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    chk("t1_data_addr_ok1", {31'd0, data_addr_ok}, 32'd0);
    sb_q.push_back(1'b0);
    tick();
    inst_req = 1'b0; m_addr_ok = 1'b0;
    @(negedge clk);
    chk("t1_idle_m_req", {31'd0, m_req}, 32'd0);
    tick();
    resp("t1_r0", 32'h1111_0001);
    resp("t1_r1", 32'h1111_0002);

    // Stalled inst handshake keeps the grant while data_req rises.
    inst_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) data_req = 1'b1;
      @(negedge clk);
      chk($sformatf("t2_lock_addr_c%0d", c), m_addr, 32'hBFC0_0000);
      chk($sformatf("t2_lock_aok_c%0d", c), {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
      tick();
    end
    m_addr_ok = 1'b1;
    @(negedge clk);
    chk("t2_c3_addr", m_addr, 32'hBFC0_0000);
    chk("t2_c3_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    chk("t2_c3_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
    sb_q.push_back(1'b0);
    tick();
    inst_req = 1'b0;
    @(negedge clk);
    chk("t2_c4_addr", m_addr, 32'h0000_1000);
    chk("t2_c4_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    sb_q.push_back(1'b1);
    tick();
    data_req = 1'b0; m_addr_ok = 1'b0;
    resp("t2_r0", 32'h2222_0001);
    resp("t2_r1", 32'h2222_0002);

    // Fill to DEPTH, then the fifth request waits out a same-cycle pop.
    inst_req = 1'b1; m_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("t3_fill_aok_%0d", i), {31'd0, inst_addr_ok}, 32'd1);
      sb_q.push_back(1'b0);
      tick();
    end
    m_data_ok = 1'b1; m_rdata = 32'h3333_0000;
    @(negedge clk);
    chk("t3_full_m_req", {31'd0, m_req}, 32'd0);
    chk("t3_full_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    check_resp("t3_full_pop", 32'h3333_0000);
    tick();
    m_data_ok = 1'b0;
    @(negedge clk);
    chk("t3_after_pop_m_req", {31'd0, m_req}, 32'd1);
    chk("t3_after_pop_aok", {31'd0, inst_addr_ok}, 32'd1);
    sb_q.push_back(1'b0);
    tick();
    inst_req = 1'b0; m_addr_ok = 1'b0;
    for (int i = 0; i < 4; i++) resp($sformatf("t3_drain_%0d", i), 32'h3333_0010 + i);

    // One push and one pop per cycle with alternating requesters.
    data_req = 1'b1; m_addr_ok = 1'b1;
    @(negedge clk);
    chk("t4_prime_aok", {31'd0, data_addr_ok}, 32'd1);
    sb_q.push_back(1'b1);
    tick();
    for (int i = 0; i < 6; i++) begin
      inst_req  = (i % 2 == 0);
      data_req  = (i % 2 == 1);
      m_data_ok = 1'b1;
      m_rdata   = 32'h4444_0000 + i;
      @(negedge clk);
      check_resp($sformatf("t4_pp%0d", i), 32'h4444_0000 + i);
      chk($sformatf("t4_pp%0d_aok", i), {30'd0, inst_addr_ok, data_addr_ok},
          (i % 2 == 0) ? 32'd2 : 32'd1);
      sb_q.push_back(i % 2 == 1);
      tick();
    end
    inst_req = 1'b0; data_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0;
    resp("t4_last", 32'h4444_00FF);

    // Orphan response while empty, sticky until async reset.
    m_data_ok = 1'b1; m_rdata = 32'h5555_0000;
    @(negedge clk);
    chk("t5_orphan_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    chk("t5_err_before_edge", {31'd0, err_orphan}, 32'd0);
    tick();
    m_data_ok = 1'b0;
    @(negedge clk);
    chk("t5_err_set", {31'd0, err_orphan}, 32'd1);
    tick();
    tick();
    chk("t5_err_sticky", {31'd0, err_orphan}, 32'd1);
    #1 resetn = 1'b0;
    #1 chk("t5_err_async_clr", {31'd0, err_orphan}, 32'd0);
    tick();
    resetn = 1'b1;
    @(negedge clk);
    chk("t5_err_after_rst", {31'd0, err_orphan}, 32'd0);
    chk("t5_sb_drained", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
